// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// UART receiver: 2-flop sync, oversampled FSM, parity/stop checks
// and a valid/ready holding register with overrun reporting.
module uart_rx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_HALF  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
  localparam logic          ODD     = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [DW-1:0]        r_div;
  logic [TW-1:0]        r_tcnt;
  logic [BW-1:0]        r_bcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_ok;
  logic                 r_done;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_good;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;

  logic w_rx;
  logic w_tick;
  logic w_start;
  logic w_load;
  logic w_ovr;

  assign w_rx    = r_sync2;
  assign w_tick  = (r_div == DIV_MAX);
  assign w_start = (r_state == S_IDLE) && !w_rx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Divider phase is realigned to the detected start edge.
  always_ff @(posedge clk) begin
    if (rst || w_start || w_tick) r_div <= '0;
    else                          r_div <= r_div + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tcnt   <= '0;
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_par_ok <= 1'b0;
      r_done   <= 1'b0;
      r_ferr   <= 1'b0;
      r_perr   <= 1'b0;
      r_good   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
            r_tcnt  <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_tcnt == T_HALF) begin
              r_tcnt <= '0;
              if (w_rx) begin
                r_state <= S_IDLE;
              end else begin
                r_state  <= S_DATA;
                r_bcnt   <= '0;
                r_par_ok <= 1'b1;
              end
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_tcnt == T_LAST) begin
              r_tcnt  <= '0;
              r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
              if (r_bcnt == B_LAST) begin
                r_bcnt  <= '0;
                r_state <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                r_bcnt <= r_bcnt + BW'(1);
              end
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end
        S_PAR: begin
          if (w_tick) begin
            if (r_tcnt == T_LAST) begin
              r_tcnt   <= '0;
              r_par_ok <= ((^{r_shift, w_rx}) == ODD);
              r_state  <= S_STOP;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_tcnt == T_LAST) begin
              r_tcnt  <= '0;
              r_done  <= 1'b1;
              r_ferr  <= !w_rx;
              r_perr  <= !r_par_ok;
              r_good  <= w_rx && r_par_ok;
              r_state <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A pending word may be replaced only when it is consumed this clock.
  assign w_load = r_done && r_good && (!r_valid || rx_ready);
  assign w_ovr  = r_done && r_good && r_valid && !rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
    end else if (r_valid && rx_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign rx_done     = r_done;
  assign frame_err   = r_ferr;
  assign parity_err  = r_perr;
  assign overrun_err = w_ovr;
  assign rx_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_param: three instances covering
// 8N1, 8E1 and 9N1 (8x oversampling), all at 64 clocks per bit.
module tb_uart_rx_param;

  localparam int BIT = 64;
  localparam int LAT = 608;
  localparam int TOL = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx  = 3'b111;
  logic [2:0] rdy = 3'b000;
  logic [7:0] d0, d1;
  logic [8:0] d2;
  logic [2:0] vld, done, fe, pe, oe, bsy;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int ndone [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (done[i]) ndone[i] <= ndone[i] + 1;

  uart_rx_param #(
    .CLK_FREQ(640_000), .BAUD(10_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0)
  ) u0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .rx_data(d0),
    .rx_valid(vld[0]), .rx_ready(rdy[0]), .rx_done(done[0]),
    .frame_err(fe[0]), .parity_err(pe[0]),
    .overrun_err(oe[0]), .rx_busy(bsy[0])
  );

  uart_rx_param #(
    .CLK_FREQ(640_000), .BAUD(10_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2)
  ) u1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .rx_data(d1),
    .rx_valid(vld[1]), .rx_ready(rdy[1]), .rx_done(done[1]),
    .frame_err(fe[1]), .parity_err(pe[1]),
    .overrun_err(oe[1]), .rx_busy(bsy[1])
  );

  uart_rx_param #(
    .CLK_FREQ(640_000), .BAUD(10_000), .OVERSAMPLE(8),
    .DATA_BITS(9), .PARITY(0)
  ) u2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .rx_data(d2),
    .rx_valid(vld[2]), .rx_ready(rdy[2]), .rx_done(done[2]),
    .frame_err(fe[2]), .parity_err(pe[2]),
    .overrun_err(oe[2]), .rx_busy(bsy[2])
  );

  function automatic logic [8:0] rdata(input int u);
    if (u == 0) return {1'b0, d0};
    if (u == 1) return {1'b0, d1};
    return d2;
  endfunction

  task automatic drive_bit(input int u, input logic b);
    rx[u] = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input int u, input logic [8:0] v,
                      input int nb, input int par,
                      input bit flip, input bit stopb);
    logic p;
    p = (par == 1);
    for (int i = 0; i < nb; i++) p = p ^ v[i];
    drive_bit(u, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(u, v[i]);
    if (par != 0) drive_bit(u, p ^ flip);
    drive_bit(u, stopb);
    rx[u] = 1'b1;
  endtask

  task automatic wait_done(input int u, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1500 && !ok; i++) begin
      @(negedge clk);
      if (done[u]) ok = 1'b1;
    end
  endtask

  task automatic xfer(input int u, input logic [8:0] v,
                      input int nb, input int par,
                      input bit flip, input bit stopb,
                      input bit rat, output bit ok,
                      output bit f, output bit p,
                      output bit o, output int lat);
    int t0;
    t0 = cyc;
    fork
      send(u, v, nb, par, flip, stopb);
      begin
        wait_done(u, ok);
        if (rat) begin
          rdy[u] = 1'b1;
          #1;
        end
        f = fe[u];
        p = pe[u];
        o = oe[u];
        lat = cyc - t0;
        if (rat) begin
          @(negedge clk);
          rdy[u] = 1'b0;
        end
      end
    join
  endtask

  task automatic consume(input int u);
    rdy[u] = 1'b1;
    @(negedge clk);
    rdy[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    nvec++;
    if ({vld, done, fe, pe, oe, bsy} !== 18'd0) begin
      nerr++;
      $display("FAIL reset_flags got %h want 0",
               {vld, done, fe, pe, oe, bsy});
    end
    nvec++;
    if ({d2, d1, d0} !== 25'd0) begin
      nerr++;
      $display("FAIL reset_data got %h want 0", {d2, d1, d0});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok, f, p, o;
    int lat, n;
    n = ndone[0];
    xfer(0, 9'h31, 8, 0, 0, 1, 0, ok, f, p, o, lat);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL basic_done got timeout want pulse");
    end
    nvec++;
    if (lat < LAT - TOL || lat > LAT + TOL) begin
      nerr++;
      $display("FAIL basic_latency got %0d want %0d+-%0d",
               lat, LAT, TOL);
    end
    nvec++;
    if ({f, p, o} !== 3'b000) begin
      nerr++;
      $display("FAIL basic_errs got %b want 000", {f, p, o});
    end
    nvec++;
    if (d0 !== 8'h31 || vld[0] !== 1'b1) begin
      nerr++;
      $display("FAIL basic_data got %h/%b want 31/1", d0, vld[0]);
    end
    nvec++;
    if (ndone[0] - n !== 1) begin
      nerr++;
      $display("FAIL basic_count got %0d want 1", ndone[0] - n);
    end
    consume(0);
    nvec++;
    if (vld[0] !== 1'b0 || d0 !== 8'h31) begin
      nerr++;
      $display("FAIL consume got %h/%b want 31/0", d0, vld[0]);
    end
  endtask

  task automatic test_parity();
    bit ok, f, p, o;
    int lat;
    xfer(1, 9'hA5, 8, 2, 0, 1, 0, ok, f, p, o, lat);
    nvec++;
    if (!ok || {f, p, o} !== 3'b000) begin
      nerr++;
      $display("FAIL par_good got ok=%b e=%b want 1/000",
               ok, {f, p, o});
    end
    nvec++;
    if (d1 !== 8'hA5 || vld[1] !== 1'b1) begin
      nerr++;
      $display("FAIL par_data got %h/%b want a5/1", d1, vld[1]);
    end
    xfer(1, 9'hA5, 8, 2, 1, 1, 0, ok, f, p, o, lat);
    nvec++;
    if (!ok || {f, p, o} !== 3'b010) begin
      nerr++;
      $display("FAIL par_bad got ok=%b e=%b want 1/010",
               ok, {f, p, o});
    end
    nvec++;
    if (d1 !== 8'hA5 || vld[1] !== 1'b1) begin
      nerr++;
      $display("FAIL par_keep got %h/%b want a5/1", d1, vld[1]);
    end
    consume(1);
  endtask

  task automatic test_frame_err();
    bit ok, f, p, o;
    int lat, n;
    n = ndone[0];
    xfer(0, 9'h55, 8, 0, 0, 0, 0, ok, f, p, o, lat);
    nvec++;
    if (!ok || {f, p, o} !== 3'b100) begin
      nerr++;
      $display("FAIL ferr_flags got ok=%b e=%b want 1/100",
               ok, {f, p, o});
    end
    nvec++;
    if (d0 !== 8'h31 || vld[0] !== 1'b0) begin
      nerr++;
      $display("FAIL ferr_keep got %h/%b want 31/0", d0, vld[0]);
    end
    repeat (200) @(negedge clk);
    nvec++;
    if (bsy[0] !== 1'b0 || ndone[0] - n !== 1) begin
      nerr++;
      $display("FAIL ferr_idle got busy=%b n=%0d want 0/1",
               bsy[0], ndone[0] - n);
    end
    xfer(0, 9'h0F, 8, 0, 0, 1, 0, ok, f, p, o, lat);
    nvec++;
    if (!ok || d0 !== 8'h0F || vld[0] !== 1'b1) begin
      nerr++;
      $display("FAIL ferr_next got %h/%b want 0f/1", d0, vld[0]);
    end
    consume(0);
  endtask

  task automatic test_overrun();
    bit ok, f, p, o;
    int lat;
    xfer(0, 9'h12, 8, 0, 0, 1, 0, ok, f, p, o, lat);
    xfer(0, 9'h34, 8, 0, 0, 1, 0, ok, f, p, o, lat);
    nvec++;
    if (!ok || {f, p, o} !== 3'b001) begin
      nerr++;
      $display("FAIL ovr_flag got ok=%b e=%b want 1/001",
               ok, {f, p, o});
    end
    nvec++;
    if (d0 !== 8'h12 || vld[0] !== 1'b1) begin
      nerr++;
      $display("FAIL ovr_keep got %h/%b want 12/1", d0, vld[0]);
    end
    consume(0);
    xfer(0, 9'h12, 8, 0, 0, 1, 0, ok, f, p, o, lat);
    xfer(0, 9'h34, 8, 0, 0, 1, 1, ok, f, p, o, lat);
    nvec++;
    if (!ok || {f, p, o} !== 3'b000) begin
      nerr++;
      $display("FAIL hs_flags got ok=%b e=%b want 1/000",
               ok, {f, p, o});
    end
    nvec++;
    if (d0 !== 8'h34 || vld[0] !== 1'b1) begin
      nerr++;
      $display("FAIL hs_data got %h/%b want 34/1", d0, vld[0]);
    end
    consume(0);
  endtask

  task automatic test_glitch();
    bit ok, f, p, o;
    int lat, n;
    n = ndone[0];
    rx[0] = 1'b0;
    repeat (12) @(negedge clk);
    nvec++;
    if (bsy[0] !== 1'b1) begin
      nerr++;
      $display("FAIL glitch_busy got %b want 1", bsy[0]);
    end
    rx[0] = 1'b1;
    repeat (100) @(negedge clk);
    nvec++;
    if (bsy[0] !== 1'b0 || ndone[0] !== n) begin
      nerr++;
      $display("FAIL glitch_rej got busy=%b n=%0d want 0/0",
               bsy[0], ndone[0] - n);
    end
    xfer(0, 9'h7E, 8, 0, 0, 1, 0, ok, f, p, o, lat);
    nvec++;
    if (!ok || d0 !== 8'h7E || {f, p, o} !== 3'b000) begin
      nerr++;
      $display("FAIL glitch_next got %h e=%b want 7e/000",
               d0, {f, p, o});
    end
    consume(0);
  endtask

  task automatic test_reset_mid();
    bit ok, f, p, o;
    int lat, n;
    n = ndone[0];
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    nvec++;
    if (bsy[0] !== 1'b1) begin
      nerr++;
      $display("FAIL mid_busy got %b want 1", bsy[0]);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (bsy[0] !== 1'b0 || d0 !== 8'h00) begin
      nerr++;
      $display("FAIL mid_reset got busy=%b d=%h want 0/00",
               bsy[0], d0);
    end
    repeat (700) @(negedge clk);
    nvec++;
    if (ndone[0] !== n || bsy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL mid_abort got n=%0d busy=%b want 0/0",
               ndone[0] - n, bsy[0]);
    end
    xfer(0, 9'h5A, 8, 0, 0, 1, 0, ok, f, p, o, lat);
    nvec++;
    if (!ok || d0 !== 8'h5A || vld[0] !== 1'b1) begin
      nerr++;
      $display("FAIL mid_next got %h/%b want 5a/1", d0, vld[0]);
    end
    consume(0);
  endtask

  task automatic test_back_to_back(input int u, input int nb);
    logic [8:0] exp [8];
    for (int k = 0; k < 8; k++)
      exp[k] = 9'($urandom_range(0, (1 << nb) - 1));
    rdy[u] = 1'b1;
    fork
      for (int k = 0; k < 8; k++)
        send(u, exp[k], nb, 0, 0, 1);
      for (int k = 0; k < 8; k++) begin
        bit ok;
        wait_done(u, ok);
        nvec++;
        if (!ok || {fe[u], pe[u], oe[u]} !== 3'b000) begin
          nerr++;
          $display("FAIL b2b_flags u%0d #%0d got ok=%b e=%b want 1/000",
                   u, k, ok, {fe[u], pe[u], oe[u]});
        end
        @(negedge clk);
        nvec++;
        if (vld[u] !== 1'b1 || rdata(u) !== exp[k]) begin
          nerr++;
          $display("FAIL b2b_data u%0d #%0d got %h/%b want %h/1",
                   u, k, rdata(u), vld[u], exp[k]);
        end
      end
    join
    rdy[u] = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_mid();
    test_back_to_back(0, 8);
    test_back_to_back(2, 9);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
